// File: rtl/avalon_byte_bridge.sv
// Byte-stream command bridge: decodes read/write command packets from a byte
// source into single Avalon-MM transactions and returns response bytes on a
// valid/ready byte sink. Exactly one transaction is in flight at a time.
//
// Handshake rule (both byte ports): a byte moves on a rising clk edge where
// valid and ready are both 1; the sender holds data stable while valid is 1
// and ready is 0, and ready never depends combinationally on valid.
module avalon_byte_bridge #(
  parameter int ADDR_WIDTH = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rxData,
  input  logic                  rxValid,
  output logic                  rxReady,
  output logic [7:0]            txData,
  output logic                  txValid,
  input  logic                  txReady,
  output logic                  avRead,
  output logic                  avWrite,
  output logic [ADDR_WIDTH-1:0] avAddress,
  output logic [31:0]           avDataOut,
  input  logic                  avReadValid,
  input  logic [31:0]           avDataIn,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WDATA  = 3'd1,
    S_WRITE  = 3'd2,
    S_READ   = 3'd3,
    S_RWAIT  = 3'd4,
    S_TXRESP = 3'd5
  } state_t;

  state_t                state, state_nxt;
  logic                  run;        // 0 while in reset, keeps rxReady low
  logic [1:0]            cnt;        // write-data byte index
  logic [TW-1:0]         timer;
  logic [TW-1:0]         timer_nxt;
  logic [31:0]           wdata;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           resp;
  logic [1:0]            resp_last;  // index of the final response byte
  logic [1:0]            idx;        // index of the response byte on txData
  logic [6:0]            op_high;
  logic                  op_illegal;
  logic                  rx_fire;
  logic                  tx_fire;
  logic                  rd_timeout;

  // Opcode bits above the address field must be zero for a legal command.
  always_comb begin
    op_high    = rxData[6:0] >> ADDR_WIDTH;
    op_illegal = |op_high;
  end

  // Outputs decoded from state and registers only.
  always_comb begin
    rxReady   = run && (state == S_IDLE || state == S_WDATA);
    txValid   = (state == S_TXRESP);
    txData    = (state == S_TXRESP) ? resp[{idx, 3'b000} +: 8] : 8'h00;
    avRead    = (state == S_READ);
    avWrite   = (state == S_WRITE);
    avAddress = addr;
    avDataOut = wdata;
    busy      = (state != S_IDLE);
    dbg_state = state;
  end

  // Handshake and timeout qualifiers shared by the FSM and the datapath.
  always_comb begin
    rx_fire    = rxValid && rxReady;
    tx_fire    = txValid && txReady;
    timer_nxt  = timer + 1'b1;
    rd_timeout = (timer_nxt == TW'(TIMEOUT));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (rx_fire) begin
          if (op_illegal)     state_nxt = S_TXRESP;
          else if (rxData[7]) state_nxt = S_WDATA;
          else                state_nxt = S_READ;
        end
      end
      S_WDATA:  if (rx_fire && cnt == 2'd3) state_nxt = S_WRITE;
      S_WRITE:  state_nxt = S_TXRESP;
      S_READ:   state_nxt = S_RWAIT;
      S_RWAIT:  if (avReadValid || rd_timeout) state_nxt = S_TXRESP;
      S_TXRESP: if (tx_fire && idx == resp_last) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath: address/data capture, read timer and response buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      run       <= 1'b0;
      cnt       <= '0;
      timer     <= '0;
      wdata     <= '0;
      addr      <= '0;
      resp      <= '0;
      resp_last <= '0;
      idx       <= '0;
    end else begin
      run <= 1'b1;
      case (state)
        S_IDLE: begin
          if (rx_fire) begin
            addr <= rxData[ADDR_WIDTH-1:0];
            cnt  <= '0;
            if (op_illegal) begin
              resp      <= 32'h0000_00EE;
              resp_last <= 2'd0;
              idx       <= 2'd0;
            end
          end
        end
        S_WDATA: begin
          if (rx_fire) begin
            wdata[{cnt, 3'b000} +: 8] <= rxData;
            cnt                       <= cnt + 1'b1;
          end
        end
        S_WRITE: begin
          resp      <= 32'h0000_00A5;
          resp_last <= 2'd0;
          idx       <= 2'd0;
        end
        S_READ: timer <= '0;
        S_RWAIT: begin
          // Read data takes priority over a coincident timeout.
          if (avReadValid) begin
            resp      <= avDataIn;
            resp_last <= 2'd3;
            idx       <= 2'd0;
          end else if (rd_timeout) begin
            resp      <= 32'h0000_00EE;
            resp_last <= 2'd0;
            idx       <= 2'd0;
          end else begin
            timer <= timer_nxt;
          end
        end
        S_TXRESP: if (tx_fire) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_byte_bridge.sv
// Bench for avalon_byte_bridge: directed scenarios plus random command
// traffic against a transaction-level reference model and a memory slave.
module tb_avalon_byte_bridge;

  localparam int AW = 2;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rxData;
  logic          rxValid;
  logic          rxReady;
  logic [7:0]    txData;
  logic          txValid;
  logic          txReady;
  logic          avRead;
  logic          avWrite;
  logic [AW-1:0] avAddress;
  logic [31:0]   avDataOut;
  logic          avReadValid;
  logic [31:0]   avDataIn;
  logic          busy;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  avalon_byte_bridge #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady),
    .txData(txData), .txValid(txValid), .txReady(txReady),
    .avRead(avRead), .avWrite(avWrite), .avAddress(avAddress),
    .avDataOut(avDataOut), .avReadValid(avReadValid), .avDataIn(avDataIn),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0]     exp_q[$];    // expected response bytes
  logic [AW+31:0] exp_wr[$];   // expected {address, data} of writes
  logic [AW-1:0]  exp_rd[$];   // expected read addresses
  logic [31:0]    ref_mem[4];  // model of slave contents
  logic [31:0]    slv_mem[4];  // slave contents as written by the DUT
  int             n_vec = 0;
  int             n_err = 0;
  int             rd_delay = 1;  // cycles from avRead to readValid; 0 = never
  logic           tx_auto = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- Avalon slave model ----------------
  initial begin : slave
    bit          pend = 0;
    bit          will_resp = 0;
    int          cnt = 0;
    logic [AW-1:0] paddr = '0;
    avReadValid = 1'b0;
    avDataIn    = '0;
    forever begin
      @(posedge clk); #1;
      avReadValid = 1'b0;
      if (!reset) begin
        pend = 0;
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          if (will_resp) begin
            avReadValid = 1'b1;
            avDataIn    = slv_mem[paddr];
          end
          pend = 0;
        end
      end else if (avRead) begin
        pend  = 1;
        paddr = avAddress;
        if (rd_delay == 0) begin will_resp = 0; cnt = TO + 2; end
        else               begin will_resp = 1; cnt = rd_delay; end
      end else if (avWrite) begin
        slv_mem[avAddress] = avDataOut;
      end else if ($urandom_range(0, 7) == 0) begin
        // stray readValid outside a read must be ignored
        avReadValid = 1'b1;
        avDataIn    = $urandom;
      end
    end
  end

  // ---------------- tx sink driver ----------------
  always @(posedge clk) begin
    #1;
    if (tx_auto) txReady = ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor ----------------
  logic       prev_wr = 1'b0, prev_rd = 1'b0, prev_hold = 1'b0;
  logic [7:0] held = '0;
  always @(negedge clk) begin
    logic [AW+31:0] e;
    if (reset) begin
      if (avWrite) begin
        check("wr_pulse", prev_wr, 1'b0);
        check("wr_expected", 32'(exp_wr.size() > 0), 1);
        if (exp_wr.size() > 0) begin
          e = exp_wr.pop_front();
          check("wr_addr", avAddress, e[AW+31:32]);
          check("wr_data", avDataOut, e[31:0]);
        end
      end
      if (avRead) begin
        check("rd_pulse", prev_rd, 1'b0);
        check("rd_expected", 32'(exp_rd.size() > 0), 1);
        if (exp_rd.size() > 0) check("rd_addr", avAddress, exp_rd.pop_front());
      end
      if (txValid) begin
        check("rx_backpressure", rxReady, 1'b0);
        if (prev_hold) check("tx_stable", txData, held);
        if (txReady) begin
          check("tx_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) check("tx_byte", txData, exp_q.pop_front());
        end
      end
      prev_hold = txValid && !txReady;
      held      = txData;
      prev_wr   = avWrite;
      prev_rd   = avRead;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    rxData  = b;
    rxValid = 1'b1;
    @(negedge clk);
    while (!rxReady && t < 100) begin t++; @(negedge clk); end
    if (t >= 100) check("rx_accept_timeout", rxReady, 1'b1);
    @(posedge clk); #1;
    rxValid = 1'b0;
    rxData  = $urandom;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while ((busy || txValid) && t < 300) begin t++; @(negedge clk); end
    check("idle_busy", busy, 1'b0);
    check("resp_left", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d);
    exp_wr.push_back({a, d});
    exp_q.push_back(8'hA5);
    ref_mem[a] = d;
    send_byte(8'h80 | 8'(a));
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    wait_idle();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int d, input bit stall);
    int k = 0;
    int lat;
    rd_delay = d;
    exp_rd.push_back(a);
    if (d == 0 || d > TO) begin
      exp_q.push_back(8'hEE);
      lat = TO + 2;
    end else begin
      for (int i = 0; i < 4; i++) exp_q.push_back(ref_mem[a][8*i +: 8]);
      lat = d + 2;
    end
    if (stall) begin tx_auto = 1'b0; txReady = 1'b1; end
    send_byte(8'(a));
    do begin @(negedge clk); k++; end while (!txValid && k < 50);
    check("rd_latency", k, lat);
    if (stall) begin
      // first byte moves on the next edge, then the sink stalls 5 cycles
      @(posedge clk); #1;
      txReady = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      txReady = 1'b1;
    end
    wait_idle();
    tx_auto = 1'b1;
  endtask

  task automatic do_illegal(input logic [7:0] op);
    exp_q.push_back(8'hEE);
    send_byte(op);
    wait_idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [7:0] op;
    int         r;
    reset   = 1'b0;
    rxValid = 1'b0;
    rxData  = '0;
    txReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ref_mem[i] = $urandom;
      slv_mem[i] = ref_mem[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rxReady", rxReady, 1'b0);
    check("rst_txValid", txValid, 1'b0);
    check("rst_txData", txData, 8'h00);
    check("rst_avRead", avRead, 1'b0);
    check("rst_avWrite", avWrite, 1'b0);
    check("rst_avAddress", avAddress, '0);
    check("rst_avDataOut", avDataOut, 32'h0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    reset   = 1'b1;
    tx_auto = 1'b1;
    @(posedge clk); #1;

    // write, then read-back with 1-cycle slave latency
    do_write(2'd0, 32'h1234_5678);
    do_write(2'd1, 32'h0000_0005);
    do_read(2'd1, 1, 1'b0);

    // timeout, coincident valid/timeout, and valid one cycle too late
    do_read(2'd2, 0, 1'b0);
    do_read(2'd0, TO, 1'b0);
    do_read(2'd3, TO + 1, 1'b0);

    // sink backpressure during a read response
    do_read(2'd1, 1, 1'b1);

    // reset in the middle of a write packet
    send_byte(8'h81);
    send_byte(8'hDE);
    send_byte(8'hAD);
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rxReady", rxReady, 1'b0);
    check("midrst_avWrite", avWrite, 1'b0);
    check("midrst_avDataOut", avDataOut, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("postrst_avWrite", avWrite, 1'b0);
    check("postrst_busy", busy, 1'b0);
    @(posedge clk); #1;
    do_write(2'd1, 32'hCAFE_F00D);
    do_read(2'd1, 2, 1'b0);

    // illegal opcode
    do_illegal(8'h40);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        do_write(AW'($urandom_range(0, 3)), $urandom);
      end else if (r < 8) begin
        r = $urandom_range(0, 11);
        do_read(AW'($urandom_range(0, 3)),
                (r < 8) ? r + 1 : (r == 8) ? TO + 1 : (r == 9) ? 0 : 1,
                ($urandom_range(0, 5) == 0));
      end else begin
        do op = 8'($urandom_range(0, 255)); while (op[6:2] == 5'd0);
        do_illegal(op);
      end
    end

    check("wr_left", exp_wr.size(), 0);
    check("rd_left", exp_rd.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
